// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler: round-robin arbiter for two requesters sharing one registered ALU, with response watchdog.
// Optional build macro ALU_SCHED_DIV_GUARD_EN answers divide-by-zero requests directly with an error.
module alu_req_scheduler #(
  parameter int OPER_WIDTH = 8,
  parameter int OUT_WIDTH  = 8,
  parameter int TIMEOUT    = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0_VALID,
  output logic                  REQ0_READY,
  input  logic [OPER_WIDTH-1:0] REQ0_A,
  input  logic [OPER_WIDTH-1:0] REQ0_B,
  input  logic [3:0]            REQ0_FUN,
  input  logic                  REQ1_VALID,
  output logic                  REQ1_READY,
  input  logic [OPER_WIDTH-1:0] REQ1_A,
  input  logic [OPER_WIDTH-1:0] REQ1_B,
  input  logic [3:0]            REQ1_FUN,
  output logic [OPER_WIDTH-1:0] ALU_A,
  output logic [OPER_WIDTH-1:0] ALU_B,
  output logic [3:0]            ALU_FUN,
  output logic                  ALU_EN,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VALID,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic                  RSP_ID,
  output logic [OUT_WIDTH-1:0]  RSP_DATA,
  output logic                  RSP_ERR
);

  // state | meaning
  // IDLE  | arbitrate between requesters, accept at most one
  // ISSUE | one-cycle ALU_EN pulse with the latched operands
  // WAIT  | wait for ALU_OUT_VALID while the watchdog counts down
  // RESP  | hold the response until RSP_READY
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int              CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WD_LOAD = CNT_W'(TIMEOUT - 1);

  logic [1:0]            state;
  logic                  pri;
  logic [CNT_W-1:0]      wd_cnt;
  logic                  gnt1;
  logic                  hs;
  logic                  div_zero;
  logic [OPER_WIDTH-1:0] sel_a;
  logic [OPER_WIDTH-1:0] sel_b;
  logic [3:0]            sel_fun;

  // READY is held low during reset so no handshake can slip through while RST is asserted.
  assign gnt1       = REQ1_VALID & (~REQ0_VALID | pri);
  assign REQ0_READY = (state == S_IDLE) & ~RST & REQ0_VALID & ~gnt1;
  assign REQ1_READY = (state == S_IDLE) & ~RST & gnt1;
  assign hs         = REQ0_READY | REQ1_READY;

  assign sel_a   = gnt1 ? REQ1_A   : REQ0_A;
  assign sel_b   = gnt1 ? REQ1_B   : REQ0_B;
  assign sel_fun = gnt1 ? REQ1_FUN : REQ0_FUN;

`ifdef ALU_SCHED_DIV_GUARD_EN
  assign div_zero = (sel_fun == 4'b0011) && (sel_b == '0);
`else
  assign div_zero = 1'b0;
`endif

  assign ALU_EN    = (state == S_ISSUE);
  assign RSP_VALID = (state == S_RESP);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      pri      <= 1'b0;
      wd_cnt   <= '0;
      ALU_A    <= '0;
      ALU_B    <= '0;
      ALU_FUN  <= '0;
      RSP_ID   <= 1'b0;
      RSP_DATA <= '0;
      RSP_ERR  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hs) begin
            pri    <= ~gnt1;
            RSP_ID <= gnt1;
            if (div_zero) begin
              RSP_DATA <= '1;
              RSP_ERR  <= 1'b1;
              state    <= S_RESP;
            end else begin
              ALU_A   <= sel_a;
              ALU_B   <= sel_b;
              ALU_FUN <= sel_fun;
              state   <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          wd_cnt <= WD_LOAD;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (ALU_OUT_VALID) begin
            RSP_DATA <= ALU_OUT;
            RSP_ERR  <= 1'b0;
            state    <= S_RESP;
          end else if (wd_cnt == '0) begin
            RSP_DATA <= '0;
            RSP_ERR  <= 1'b1;
            state    <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (RSP_READY) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Scoreboard bench for alu_req_scheduler: randomized requesters, behavioural ALU and arbitration model.
// Build with ALU_SCHED_DIV_GUARD_EN defined to check the divide-by-zero short-circuit instead.
module tb_alu_req_scheduler;
  localparam int OW = 8;
  localparam int RW = 8;
  localparam int TO = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ0_VALID, REQ1_VALID, REQ0_READY, REQ1_READY;
  logic [OW-1:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic [3:0]    REQ0_FUN, REQ1_FUN;
  logic [OW-1:0] ALU_A, ALU_B;
  logic [3:0]    ALU_FUN;
  logic          ALU_EN;
  logic [RW-1:0] ALU_OUT;
  logic          ALU_OUT_VALID;
  logic          RSP_VALID, RSP_READY, RSP_ID, RSP_ERR;
  logic [RW-1:0] RSP_DATA;

  always #5 CLK = ~CLK;

  alu_req_scheduler #(.OPER_WIDTH(OW), .OUT_WIDTH(RW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_FUN(REQ0_FUN),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_FUN(REQ1_FUN),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR)
  );

  typedef struct { logic [OW-1:0] a; logic [OW-1:0] b; logic [3:0] f; } req_t;
  typedef struct { logic id; logic [RW-1:0] data; logic err; int cyc; } rsp_t;

  req_t rq0[$];
  req_t rq1[$];
  rsp_t exp_q[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;
  bit   busy     = 0;
  logic pri      = 1'b0;
  int   en_cyc   = -1;
  logic [OW-1:0] en_a, en_b;
  logic [3:0]    en_f;
  bit   prev_rv  = 0;
  bit   late_rep = 0;
  logic drop_next = 1'b0;
  logic cur_drop  = 1'b0;
  logic noise_en  = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [RW-1:0] alu_fn(logic [3:0] f, logic [OW-1:0] a, logic [OW-1:0] b);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return (b == 0) ? '1 : a / b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // Registered ALU; may drop results (watchdog) or raise spurious valids while a response is held.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      ALU_OUT_VALID <= 1'b0;
      ALU_OUT       <= '0;
    end else if (ALU_EN && !cur_drop) begin
      ALU_OUT_VALID <= 1'b1;
      ALU_OUT       <= alu_fn(ALU_FUN, ALU_A, ALU_B);
    end else if (noise_en && RSP_VALID && ($urandom_range(1, 0) == 1)) begin
      ALU_OUT_VALID <= 1'b1;
      ALU_OUT       <= RW'($urandom);
    end else begin
      ALU_OUT_VALID <= 1'b0;
    end
  end

  // Monitor / scoreboard
  always @(negedge CLK) begin : mon
    logic e0, e1, id, guard;
    logic [OW-1:0] a, b;
    logic [3:0] f;
    cycle++;
    if (RST) begin
      check("reset_outputs",
            {REQ0_READY, REQ1_READY, ALU_EN, ALU_A, ALU_B, ALU_FUN, RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR}, 64'd0);
      exp_q.delete();
      busy = 0; pri = 1'b0; en_cyc = -1; prev_rv = 0; late_rep = 0;
    end else begin
      if (!busy && (REQ0_VALID || REQ1_VALID)) begin
        e0 = REQ0_VALID && (!REQ1_VALID || pri == 1'b0);
        e1 = REQ1_VALID && (!REQ0_VALID || pri == 1'b1);
        check("grant", {REQ1_READY, REQ0_READY}, {e1, e0});
      end else if (busy && (REQ0_VALID || REQ1_VALID)) begin
        check("ready_while_busy", {REQ1_READY, REQ0_READY}, 2'b00);
      end

      if ((REQ0_VALID && REQ0_READY) || (REQ1_VALID && REQ1_READY)) begin
        id = REQ1_VALID && REQ1_READY;
        a  = id ? REQ1_A : REQ0_A;
        b  = id ? REQ1_B : REQ0_B;
        f  = id ? REQ1_FUN : REQ0_FUN;
        pri = ~id;
        busy = 1;
        cur_drop = drop_next;
`ifdef ALU_SCHED_DIV_GUARD_EN
        guard = (f == 4'd3) && (b == 0);
`else
        guard = 1'b0;
`endif
        if (guard) begin
          exp_q.push_back('{id, {RW{1'b1}}, 1'b1, cycle + 1});
        end else begin
          en_cyc = cycle + 1; en_a = a; en_b = b; en_f = f;
          if (cur_drop) exp_q.push_back('{id, {RW{1'b0}}, 1'b1, cycle + TO + 2});
          else          exp_q.push_back('{id, alu_fn(f, a, b), 1'b0, cycle + 3});
        end
      end

      if (ALU_EN || cycle == en_cyc) begin
        check("alu_en", ALU_EN, cycle == en_cyc);
        if (cycle == en_cyc) check("alu_operands", {ALU_FUN, ALU_A, ALU_B}, {en_f, en_a, en_b});
      end

      if (RSP_VALID) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_rsp: got id=%0d data=%0h err=%0d with no request outstanding (cycle %0d)",
                   RSP_ID, RSP_DATA, RSP_ERR, cycle);
        end else begin
          if (!prev_rv) check("rsp_latency", cycle, exp_q[0].cyc);
          check("rsp_id_err_data", {RSP_ID, RSP_ERR, RSP_DATA}, {exp_q[0].id, exp_q[0].err, exp_q[0].data});
          if (RSP_READY) begin
            void'(exp_q.pop_front());
            busy = 0; late_rep = 0;
          end
        end
      end else if (exp_q.size() > 0 && cycle > exp_q[0].cyc && !late_rep) begin
        n_checks++; n_fail++; late_rep = 1;
        $display("FAIL rsp_missing: got no RSP_VALID, expected by cycle %0d (cycle %0d)", exp_q[0].cyc, cycle);
      end
      prev_rv = RSP_VALID && !RSP_READY;
    end
  end

  // Requester driver: VALID stays high until accepted, then the next queued request follows.
  initial begin : drv
    logic h0, h1;
    req_t r;
    REQ0_VALID = 0; REQ1_VALID = 0;
    REQ0_A = '0; REQ0_B = '0; REQ0_FUN = '0;
    REQ1_A = '0; REQ1_B = '0; REQ1_FUN = '0;
    forever begin
      @(negedge CLK);
      h0 = REQ0_VALID && REQ0_READY;
      h1 = REQ1_VALID && REQ1_READY;
      @(posedge CLK); #1;
      if (h0 || !REQ0_VALID) begin
        if (rq0.size() > 0) begin
          r = rq0.pop_front(); REQ0_A = r.a; REQ0_B = r.b; REQ0_FUN = r.f; REQ0_VALID = 1;
        end else REQ0_VALID = 0;
      end
      if (h1 || !REQ1_VALID) begin
        if (rq1.size() > 0) begin
          r = rq1.pop_front(); REQ1_A = r.a; REQ1_B = r.b; REQ1_FUN = r.f; REQ1_VALID = 1;
        end else REQ1_VALID = 0;
      end
    end
  end

  task automatic wait_quiet(int budget);
    int k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while ((rq0.size() > 0 || rq1.size() > 0 || REQ0_VALID || REQ1_VALID || busy || exp_q.size() > 0)
               && k < budget);
    if (k >= budget) begin
      n_checks++; n_fail++;
      $display("FAIL quiet_timeout: got busy after %0d cycles, expected idle (cycle %0d)", k, cycle);
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.a = OW'($urandom);
    r.b = ($urandom_range(4, 0) == 0) ? '0 : OW'($urandom);
    r.f = 4'($urandom_range(6, 0));
    return r;
  endfunction

  initial begin : stim
    int k;
    RST = 1; RSP_READY = 1;
    repeat (3) @(posedge CLK);
    #1 RST = 0;

    // single requester: 5 + 3
    rq0.push_back('{8'd5, 8'd3, 4'd0});
    wait_quiet(40);

    // both requesters continuously, alternating grants
    for (int i = 0; i < 4; i++) begin
      rq0.push_back('{8'd9, 8'd4, 4'd1});
      rq1.push_back('{8'd7, 8'd2, 4'd1});
    end
    wait_quiet(80);

    // response back-pressure with another request pending
    @(posedge CLK); #1 RSP_READY = 0;
    rq1.push_back('{8'd20, 8'd7, 4'd1});
    k = 0;
    while (!RSP_VALID && k < 20) begin @(negedge CLK); k++; end
    rq0.push_back('{8'd3, 8'd3, 4'd0});
    repeat (6) @(negedge CLK);
    @(posedge CLK); #1 RSP_READY = 1;
    wait_quiet(40);

    // watchdog timeout
    drop_next = 1;
    rq0.push_back('{8'd1, 8'd1, 4'd0});
    wait_quiet(40);
    drop_next = 0;

    // divide by zero
    rq1.push_back('{8'd10, 8'd0, 4'd3});
    wait_quiet(40);

    // reset while waiting on the ALU
    drop_next = 1;
    rq0.push_back('{8'd1, 8'd2, 4'd0});
    k = 0;
    while (!ALU_EN && k < 20) begin @(negedge CLK); k++; end
    repeat (2) @(negedge CLK);
    #1 RST = 1;
    drop_next = 0;
    rq0.push_back('{8'd4, 8'd4, 4'd0});
    rq1.push_back('{8'd6, 8'd1, 4'd1});
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    wait_quiet(60);

    // randomized traffic
    noise_en = 1;
    for (int i = 0; i < 600; i++) begin
      @(posedge CLK); #1;
      if (rq0.size() == 0 && $urandom_range(3, 0) == 0) rq0.push_back(rand_req());
      if (rq1.size() == 0 && $urandom_range(3, 0) == 0) rq1.push_back(rand_req());
      RSP_READY = ($urandom_range(3, 0) != 0);
      drop_next = ($urandom_range(7, 0) == 0);
    end
    RSP_READY = 1; drop_next = 0;
    wait_quiet(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test, expected finish before 500000 time units");
    $fatal(1);
  end

endmodule
